// File: rtl/sid_bus_pkg.sv
// Shared definitions for the SID bus initiator: command word layout, op codes,
// sequencer states and SID register addresses.
package sid_bus_pkg;

    localparam int CMD_W = 24;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_WAIT  = 2'b01,
        OP_READ  = 2'b10,
        OP_NOP   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_WAIT_T
    } state_e;

    // Command word fields; bit 21 is reserved and ignored.
    localparam int OP_HI   = 23;
    localparam int OP_LO   = 22;
    localparam int ADDR_HI = 20;
    localparam int ADDR_LO = 16;
    localparam int PAY_HI  = 15;
    localparam int PAY_LO  = 0;

    localparam logic [4:0] REG_V1_FREQ_LO = 5'h00;
    localparam logic [4:0] REG_V1_FREQ_HI = 5'h01;
    localparam logic [4:0] REG_V1_PW_LO   = 5'h02;
    localparam logic [4:0] REG_V1_PW_HI   = 5'h03;
    localparam logic [4:0] REG_V1_CTRL    = 5'h04;
    localparam logic [4:0] REG_V1_AD      = 5'h05;
    localparam logic [4:0] REG_V1_SR      = 5'h06;
    localparam logic [4:0] REG_V2_FREQ_LO = 5'h07;
    localparam logic [4:0] REG_V2_FREQ_HI = 5'h08;
    localparam logic [4:0] REG_V2_PW_LO   = 5'h09;
    localparam logic [4:0] REG_V2_PW_HI   = 5'h0A;
    localparam logic [4:0] REG_V2_CTRL    = 5'h0B;
    localparam logic [4:0] REG_V2_AD      = 5'h0C;
    localparam logic [4:0] REG_V2_SR      = 5'h0D;
    localparam logic [4:0] REG_V3_FREQ_LO = 5'h0E;
    localparam logic [4:0] REG_V3_FREQ_HI = 5'h0F;
    localparam logic [4:0] REG_V3_PW_LO   = 5'h10;
    localparam logic [4:0] REG_V3_PW_HI   = 5'h11;
    localparam logic [4:0] REG_V3_CTRL    = 5'h12;
    localparam logic [4:0] REG_V3_AD      = 5'h13;
    localparam logic [4:0] REG_V3_SR      = 5'h14;
    localparam logic [4:0] REG_FC_LO      = 5'h15;
    localparam logic [4:0] REG_FC_HI      = 5'h16;
    localparam logic [4:0] REG_RES_FILT   = 5'h17;
    localparam logic [4:0] REG_MODE_VOL   = 5'h18;
    localparam logic [4:0] REG_POT_X      = 5'h19;
    localparam logic [4:0] REG_POT_Y      = 5'h1A;
    localparam logic [4:0] REG_OSC3       = 5'h1B;
    localparam logic [4:0] REG_ENV3       = 5'h1C;

    function automatic op_e cmd_op(input logic [CMD_W-1:0] c);
        return op_e'(c[OP_HI:OP_LO]);
    endfunction

    function automatic logic [4:0] cmd_addr(input logic [CMD_W-1:0] c);
        return c[ADDR_HI:ADDR_LO];
    endfunction

    function automatic logic [15:0] cmd_payload(input logic [CMD_W-1:0] c);
        return c[PAY_HI:PAY_LO];
    endfunction

    function automatic logic [7:0] cmd_byte(input logic [CMD_W-1:0] c);
        return c[7:0];
    endfunction

endpackage

// File: rtl/sid_cmd_fifo.sv
// Synchronous command FIFO with clear; pointers carry one wrap bit so full and
// empty are distinguished without a separate counter.
module sid_cmd_fifo #(
    parameter int FIFO_DEPTH = 16,
    parameter int WIDTH      = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO may still accept.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && !clear && do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/sid_bus_writer.sv
// Paces queued WRITE/WAIT/READ/NOP commands onto the SID register port, one bus
// op per ce_1m tick. Define SID_BUS_WRITER_READBACK_EN to enable the READ op.
module sid_bus_writer
    import sid_bus_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce_1m,
    input  logic        abort,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [23:0] cmd_data,
    output logic        sid_we,
    output logic [4:0]  sid_addr,
    output logic [7:0]  sid_dout,
    input  logic [7:0]  sid_din,
    output logic        rd_valid,
    output logic [7:0]  rd_data,
    output logic        busy
);
    state_e           state;
    logic [CMD_W-1:0] cur_cmd;
    logic [15:0]      wait_cnt;
    logic             rdy_en;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CMD_W-1:0] fifo_rdata;
    logic             unused_bits;

    // Commands that finish in IDLE (NOP, zero WAIT) never reach ARM.
    function automatic logic needs_arm(input logic [CMD_W-1:0] c);
        case (cmd_op(c))
            OP_WRITE: return 1'b1;
            OP_WAIT:  return cmd_payload(c) != 16'd0;
`ifdef SID_BUS_WRITER_READBACK_EN
            OP_READ:  return 1'b1;
`endif
            default:  return 1'b0;
        endcase
    endfunction

    assign fifo_pop  = (state == ST_IDLE) && !fifo_empty && !abort;
    assign cmd_ready = reset && rdy_en && (!fifo_full || fifo_pop);
    assign fifo_push = cmd_valid && cmd_ready && !abort;
    assign busy      = (state != ST_IDLE) || !fifo_empty;

    always_ff @(posedge clk) begin
        rdy_en <= reset;
    end

    sid_cmd_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (abort),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (cmd_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            sid_we   <= 1'b0;
            sid_addr <= '0;
            sid_dout <= '0;
        end else if (abort) begin
            state  <= ST_IDLE;
            sid_we <= 1'b0;
        end else begin
            sid_we <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        cur_cmd <= fifo_rdata;
                        // Address and data are presented for the whole ARM wait.
                        if (cmd_op(fifo_rdata) == OP_WRITE) begin
                            sid_addr <= cmd_addr(fifo_rdata);
                            sid_dout <= cmd_byte(fifo_rdata);
                        end
`ifdef SID_BUS_WRITER_READBACK_EN
                        if (cmd_op(fifo_rdata) == OP_READ) sid_addr <= cmd_addr(fifo_rdata);
`endif
                        if (needs_arm(fifo_rdata)) state <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    case (cmd_op(cur_cmd))
                        OP_WRITE: begin
                            if (ce_1m) begin
                                sid_we <= 1'b1;
                                state  <= ST_IDLE;
                            end
                        end
                        OP_WAIT: begin
                            wait_cnt <= cmd_payload(cur_cmd);
                            state    <= ST_WAIT_T;
                        end
`ifdef SID_BUS_WRITER_READBACK_EN
                        OP_READ: begin
                            if (ce_1m) state <= ST_IDLE;
                        end
`endif
                        default: state <= ST_IDLE;
                    endcase
                end
                ST_WAIT_T: begin
                    if (ce_1m) begin
                        wait_cnt <= wait_cnt - 16'd1;
                        if (wait_cnt == 16'd1) state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef SID_BUS_WRITER_READBACK_EN
    logic       rd_fire;
    logic       rd_valid_r;
    logic [7:0] rd_data_r;

    assign rd_fire = (state == ST_ARM) && (cmd_op(cur_cmd) == OP_READ) && ce_1m && !abort;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_valid_r <= 1'b0;
            rd_data_r  <= '0;
        end else begin
            rd_valid_r <= rd_fire;
            if (rd_fire) rd_data_r <= sid_din;
        end
    end

    assign rd_valid    = rd_valid_r;
    assign rd_data     = rd_data_r;
    assign unused_bits = cur_cmd[21];
`else
    assign rd_valid    = 1'b0;
    assign rd_data     = 8'h00;
    assign unused_bits = cur_cmd[21] ^ (^sid_din);
`endif

endmodule
